pcnt_quad_decoder: RTL and testbench

// - Input conditioning stage directly upstream of the pcnt logical tile.
// - Synchronises and glitch-filters two raw pin channels (A/B) and decodes them into

---
 rtl/pcnt_pkg.sv | 24 ++
 rtl/pcnt_glitch_filter.sv | 52 +++++
 rtl/pcnt_quad_decoder.sv | 138 +++++++++++++
 tb/tb_pcnt_quad_decoder.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pcnt_pkg.sv
// pcnt_pkg: shared definitions for the pcnt input-conditioning stage.
//   - pcnt_mode_e : decoder operating mode encoding (matches cfg_mode_i)
//   - default synchroniser depth and glitch-filter counter width
//   - quad_pos    : maps a {B,A} sample onto its position in the forward
//                   quadrature cycle 00->01->11->10
package pcnt_pkg;

  typedef enum logic [1:0] {
    PCNT_MODE_DISABLED = 2'd0,
    PCNT_MODE_PULSE    = 2'd1,
    PCNT_MODE_QUAD_X1  = 2'd2,
    PCNT_MODE_QUAD_X4  = 2'd3
  } pcnt_mode_e;

  localparam int PCNT_SYNC_STAGES_DEF = 2;
  localparam int PCNT_FILT_W_DEF      = 4;

  // Position in the forward cycle: 00->0, 01->1, 11->2, 10->3.
  // A step of +1 (mod 4) is "up", -1 is "down".
  function automatic logic [1:0] quad_pos(input logic [1:0] ba);
    return {ba[1], ba[1] ^ ba[0]};
  endfunction

endpackage

// File: rtl/pcnt_glitch_filter.sv
// pcnt_glitch_filter: one pin channel's synchroniser plus threshold filter.
//   clk, rst : clock, asynchronous active-high reset
//   pin      : raw asynchronous pin
//   thr      : differing samples required beyond the first before a level is accepted
//   bypass   : when high the synchronised level is copied straight to filt
//   filt     : filtered, synchronous level
module pcnt_glitch_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pin,
  input  logic [FILT_W-1:0] thr,
  input  logic              bypass,
  output logic              filt
);

  logic [SYNC_STAGES-1:0] sync;
  logic [FILT_W-1:0]      cnt;
  logic                   s;

  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pin};
    end
  end

  // Equality (not >=) is intentional: if thr is lowered below a live cnt,
  // the counter wraps through 2^FILT_W and the level is accepted on the match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt <= 1'b0;
      cnt  <= '0;
    end else if (bypass) begin
      filt <= s;
      cnt  <= '0;
    end else if (s == filt) begin
      cnt  <= '0;
    end else if (cnt == thr) begin
      filt <= s;
      cnt  <= '0;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pcnt_quad_decoder.sv
// pcnt_quad_decoder: conditions raw A/B pins and decodes them into count
// strobes for the pcnt counter tile.
//   pcnt_clk_i, pcnt_rst_i  : clock, asynchronous active-high reset
//   pcnt_ch_a_i, pcnt_ch_b_i: raw pin channels
//   cfg_mode_i              : DISABLED / PULSE / QUAD_X1 / QUAD_X4
//   cfg_filt_thr_i          : glitch-filter threshold (0 = minimum filtering)
//   pcnt_event_o            : 1-cycle count strobe
//   pcnt_up_down_o          : count direction (1 = up), held between events
//   pcnt_err_o              : 1-cycle pulse on a two-bit quadrature jump
// There are no handshakes: every output is a registered level/strobe that the
// counter samples on each clock.
module pcnt_quad_decoder
  import pcnt_pkg::*;
#(
  parameter int SYNC_STAGES = PCNT_SYNC_STAGES_DEF,
  parameter int FILT_W      = PCNT_FILT_W_DEF
) (
  input  logic              pcnt_clk_i,
  input  logic              pcnt_rst_i,
  input  logic              pcnt_ch_a_i,
  input  logic              pcnt_ch_b_i,
  input  logic [1:0]        cfg_mode_i,
  input  logic [FILT_W-1:0] cfg_filt_thr_i,
  output logic              pcnt_event_o,
  output logic              pcnt_up_down_o,
  output logic              pcnt_err_o
);

  // Filter bypass covers the synchroniser fill plus the cycle that loads
  // filt; decode stays quiet one cycle longer so prev catches up with filt
  // before any comparison counts.
  localparam int WARM_BYP = SYNC_STAGES + 1;
  localparam int WARM_END = SYNC_STAGES + 2;
  localparam int WARM_W   = $clog2(WARM_END + 1);

  logic [WARM_W-1:0] warm_cnt;
  logic              bypass;
  logic              quiet;
  logic              filt_a;
  logic              filt_b;
  logic [1:0]        cur;
  logic [1:0]        prev;
  logic [1:0]        diff;
  logic [1:0]        step;
  pcnt_mode_e        mode;

  logic              event_d;
  logic              up_down_d;
  logic              err_d;

  assign bypass = (warm_cnt < WARM_W'(WARM_BYP));
  assign quiet  = (warm_cnt != WARM_W'(WARM_END));

  always_ff @(posedge pcnt_clk_i or posedge pcnt_rst_i) begin
    if (pcnt_rst_i) begin
      warm_cnt <= '0;
    end else if (quiet) begin
      warm_cnt <= warm_cnt + 1'b1;
    end
  end

  pcnt_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_W(FILT_W)) u_filt_a (
    .clk    (pcnt_clk_i),
    .rst    (pcnt_rst_i),
    .pin    (pcnt_ch_a_i),
    .thr    (cfg_filt_thr_i),
    .bypass (bypass),
    .filt   (filt_a)
  );

  pcnt_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_W(FILT_W)) u_filt_b (
    .clk    (pcnt_clk_i),
    .rst    (pcnt_rst_i),
    .pin    (pcnt_ch_b_i),
    .thr    (cfg_filt_thr_i),
    .bypass (bypass),
    .filt   (filt_b)
  );

  assign cur  = {filt_b, filt_a};
  assign diff = cur ^ prev;
  assign step = quad_pos(cur) - quad_pos(prev);
  assign mode = pcnt_mode_e'(cfg_mode_i);

  // prev tracks filt in every mode, so a mode switch never sees a stale edge.
  always_ff @(posedge pcnt_clk_i or posedge pcnt_rst_i) begin
    if (pcnt_rst_i) begin
      prev <= 2'b00;
    end else begin
      prev <= cur;
    end
  end

  always_comb begin
    event_d   = 1'b0;
    err_d     = 1'b0;
    up_down_d = pcnt_up_down_o;
    if (!quiet) begin
      unique case (mode)
        PCNT_MODE_PULSE: begin
          if (filt_a && !prev[0]) begin
            event_d   = 1'b1;
            up_down_d = filt_b;
          end
        end
        PCNT_MODE_QUAD_X1: begin
          if (filt_a && !prev[0]) begin
            event_d   = 1'b1;
            up_down_d = ~filt_b;
          end
        end
        PCNT_MODE_QUAD_X4: begin
          if (diff == 2'b11) begin
            err_d = 1'b1;
          end else if (diff != 2'b00) begin
            event_d   = 1'b1;
            up_down_d = (step == 2'd1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge pcnt_clk_i or posedge pcnt_rst_i) begin
    if (pcnt_rst_i) begin
      pcnt_event_o   <= 1'b0;
      pcnt_up_down_o <= 1'b1;
      pcnt_err_o     <= 1'b0;
    end else begin
      pcnt_event_o   <= event_d;
      pcnt_up_down_o <= up_down_d;
      pcnt_err_o     <= err_d;
    end
  end

endmodule

// File: tb/tb_pcnt_quad_decoder.sv
module tb_pcnt_quad_decoder;

  logic       clk;
  logic       rst;
  logic       ch_a;
  logic       ch_b;
  logic [1:0] mode;
  logic [3:0] thr;
  logic       ev;
  logic       up_down;
  logic       err;

  int vectors;
  int miscompares;
  int cyc;
  int ev_cnt;
  int err_cnt;
  int first_ev_cyc;
  int last_ev_cyc;
  int mark_cyc;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  pcnt_quad_decoder dut (
    .pcnt_clk_i     (clk),
    .pcnt_rst_i     (rst),
    .pcnt_ch_a_i    (ch_a),
    .pcnt_ch_b_i    (ch_b),
    .cfg_mode_i     (mode),
    .cfg_filt_thr_i (thr),
    .pcnt_event_o   (ev),
    .pcnt_up_down_o (up_down),
    .pcnt_err_o     (err)
  );

  // ---------------- driver tasks ----------------
  // Advance to the next falling edge and tally whatever the DUT strobed.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (ev === 1'b1) begin
      ev_cnt++;
      if (first_ev_cyc < 0) first_ev_cyc = cyc;
      last_ev_cyc = cyc;
    end
    if (err === 1'b1) err_cnt++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive(input logic [1:0] ba);
    ch_b = ba[1];
    ch_a = ba[0];
  endtask

  task automatic clr();
    ev_cnt       = 0;
    err_cnt      = 0;
    first_ev_cyc = -1;
    last_ev_cyc  = -1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    clr();
    rst  = 1'b1;
    ch_a = 1'b1;
    ch_b = 1'b1;
    mode = 2'd1;
    thr  = 4'd0;

    // Reset values with both pins high, PULSE mode.
    run(3);
    check("rst_event", ev, 1'b0);
    check("rst_up_down", up_down, 1'b1);
    check("rst_err", err, 1'b0);
    rst = 1'b0;
    clr();
    run(20);
    check("warm_no_event", ev_cnt, 0);
    check("warm_no_err", err_cnt, 0);

    // PULSE thr=0: pins fall (no event), then a 3-cycle A pulse with B low.
    drive(2'b00);
    run(10);
    check("pulse_fall_no_event", ev_cnt, 0);
    clr();
    drive(2'b01);
    mark_cyc = cyc;
    run(3);
    drive(2'b00);
    run(10);
    check("pulse_count", ev_cnt, 1);
    check("pulse_latency", last_ev_cyc - mark_cyc, 4);
    check("pulse_up_down", up_down, 1'b0);

    // thr=5: B high first, 5-cycle A glitch is rejected, long A high counts.
    thr = 4'd5;
    drive(2'b10);
    run(15);
    clr();
    drive(2'b11);
    run(5);
    drive(2'b10);
    run(20);
    check("glitch_rejected", ev_cnt, 0);
    drive(2'b11);
    mark_cyc = cyc;
    run(20);
    check("thr5_count", ev_cnt, 1);
    check("thr5_latency", last_ev_cyc - mark_cyc, 9);
    check("thr5_up_down", up_down, 1'b1);
    drive(2'b00);
    run(20);

    // QUAD_X4 thr=0: forward cycle spaced 4 cycles.
    thr  = 4'd0;
    mode = 2'd3;
    run(2);
    clr();
    mark_cyc = cyc;
    drive(2'b01); run(4);
    drive(2'b11); run(4);
    drive(2'b10); run(4);
    drive(2'b00); run(8);
    check("x4_fwd_count", ev_cnt, 4);
    check("x4_fwd_latency", first_ev_cyc - mark_cyc, 4);
    check("x4_fwd_up_down", up_down, 1'b1);
    check("x4_fwd_err", err_cnt, 0);

    // Reverse cycle.
    clr();
    drive(2'b10); run(4);
    drive(2'b11); run(4);
    drive(2'b01); run(4);
    drive(2'b00); run(8);
    check("x4_rev_count", ev_cnt, 4);
    check("x4_rev_up_down", up_down, 1'b0);

    // Back-to-back steps one cycle apart: four strobes on consecutive cycles.
    clr();
    drive(2'b01); run(1);
    drive(2'b11); run(1);
    drive(2'b10); run(1);
    drive(2'b00); run(10);
    check("x4_b2b_count", ev_cnt, 4);
    check("x4_b2b_span", last_ev_cyc - first_ev_cyc, 3);
    check("x4_b2b_up_down", up_down, 1'b1);

    // Two-bit jump 00->11 and back: error strobes, no events, direction held.
    clr();
    drive(2'b11);
    run(10);
    check("x4_jump_err", err_cnt, 1);
    check("x4_jump_no_event", ev_cnt, 0);
    check("x4_jump_up_down", up_down, 1'b1);
    drive(2'b00);
    run(10);
    check("x4_jump_back_err", err_cnt, 2);

    // QUAD_X1: reverse cycle counts once down, forward cycle counts once up.
    mode = 2'd2;
    run(2);
    clr();
    drive(2'b10); run(4);
    drive(2'b11); run(4);
    drive(2'b01); run(4);
    drive(2'b00); run(8);
    check("x1_rev_count", ev_cnt, 1);
    check("x1_rev_up_down", up_down, 1'b0);
    clr();
    drive(2'b01); run(4);
    drive(2'b11); run(4);
    drive(2'b10); run(4);
    drive(2'b00); run(8);
    check("x1_fwd_count", ev_cnt, 1);
    check("x1_fwd_up_down", up_down, 1'b1);

    // DISABLED: full cycle gives nothing; re-enable with A already high.
    mode = 2'd0;
    clr();
    drive(2'b01); run(4);
    drive(2'b11); run(4);
    drive(2'b10); run(4);
    drive(2'b00); run(8);
    check("disabled_count", ev_cnt, 0);
    drive(2'b01);
    run(6);
    mode = 2'd2;
    run(10);
    check("reenable_no_spurious", ev_cnt, 0);
    check("reenable_up_down", up_down, 1'b1);

    // X4 down step, then reset asserted mid-sequence between clock edges.
    mode = 2'd3;
    clr();
    drive(2'b00);
    run(8);
    check("pre_rst_count", ev_cnt, 1);
    check("pre_rst_up_down", up_down, 1'b0);
    drive(2'b01);
    run(3);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_event", ev, 1'b0);
    check("midrst_up_down", up_down, 1'b1);
    check("midrst_err", err, 1'b0);
    run(2);
    rst = 1'b0;
    clr();
    run(20);
    check("post_rst_no_event", ev_cnt, 0);
    check("post_rst_no_err", err_cnt, 0);
    drive(2'b00);
    run(8);
    check("post_rst_count", ev_cnt, 1);
    check("post_rst_up_down", up_down, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
